// File: rtl/cva6_spi_pkg.sv
// Shared SPI slave definitions: mode encoding and byte geometry.
package cva6_spi_pkg;

    localparam int unsigned SPI_BYTE_BITS = 8;
    localparam int unsigned SPI_CNT_BITS  = $clog2(SPI_BYTE_BITS);

    // Mode number is {cpol, cpha}
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    // Modes 0 and 3 capture MOSI on the rising SCLK edge, modes 1 and 2 on the falling edge
    function automatic logic sample_on_rise(input spi_mode_e mode);
        return (mode == MODE0) || (mode == MODE3);
    endfunction

endpackage

// File: rtl/cva6_spi_sync_edge.sv
// N-stage synchroniser for an asynchronous pin plus 1-cycle rise/fall strobes.
module cva6_spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    // Synchroniser chain followed by one extra flop for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {STAGES{RESET_VAL}};
            last_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~last_q;
    assign fall_o = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/cva6_spi_slave_clkrec.sv
// SPI slave: oversampled SCLK recovery, MOSI byte assembly and MISO serialisation.
module cva6_spi_slave_clkrec
    import cva6_spi_pkg::*;
#(
    parameter int unsigned              SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_BITS-1:0] TX_IDLE     = 8'hFF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic                     cpol,
    input  logic                     cpha,
    input  logic                     spi_sclk,
    input  logic                     spi_cs_n,
    input  logic                     spi_mosi,
    output logic                     spi_miso,
    output logic                     spi_miso_oe,
    output logic [SPI_BYTE_BITS-1:0] rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     rx_overrun,
    input  logic [SPI_BYTE_BITS-1:0] tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic                     tx_underrun
);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_n_s, cs_fall, cs_rise_unused;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    cva6_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rstn   (rstn),
        .d_i    (spi_sclk),
        .q_o    (sclk_lvl_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    cva6_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .rstn   (rstn),
        .d_i    (spi_cs_n),
        .q_o    (cs_n_s),
        .rise_o (cs_rise_unused),
        .fall_o (cs_fall)
    );

    // MOSI needs only a plain synchroniser, same depth keeps it aligned with SCLK
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) mosi_sync_q <= '0;
        else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    spi_mode_e mode;
    logic      active, sample_edge, shift_edge, load;

    assign mode        = spi_mode_e'({cpol, cpha});
    assign active      = en & ~cs_n_s;
    assign sample_edge = active & (sample_on_rise(mode) ? sclk_rise : sclk_fall);
    assign shift_edge  = active & (sample_on_rise(mode) ? sclk_fall : sclk_rise);

    logic [SPI_BYTE_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d, rx_byte;
    logic [SPI_BYTE_BITS-1:0] tx_shift_q, tx_shift_d, hold_q, hold_d;
    logic [SPI_CNT_BITS-1:0]  bit_cnt_q, bit_cnt_d;
    logic rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
    logic hold_valid_q, hold_valid_d, tx_udr_q, tx_udr_d;

    assign rx_byte = {rx_shift_q[SPI_BYTE_BITS-2:0], mosi_s};
    assign load    = (cs_fall & en & ~cpha) | (shift_edge & (bit_cnt_q == '0));

    // Next-state for receive shifter, bit counter, TX holding and shift registers
    always_comb begin
        rx_shift_d   = rx_shift_q;
        bit_cnt_d    = bit_cnt_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_ovr_d     = 1'b0;
        tx_shift_d   = tx_shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        tx_udr_d     = 1'b0;

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        // Leaving the active state (cs high or disable) restarts the byte
        if (!active) begin
            bit_cnt_d = '0;
        end else if (sample_edge) begin
            rx_shift_d = rx_byte;
            bit_cnt_d  = bit_cnt_q + SPI_CNT_BITS'(1);
            if (bit_cnt_q == SPI_CNT_BITS'(SPI_BYTE_BITS - 1)) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_d  = rx_byte;
                    rx_valid_d = 1'b1;
                end else begin
                    rx_ovr_d = 1'b1;
                end
            end
        end

        if (load) begin
            if (hold_valid_q) begin
                tx_shift_d   = hold_q;
                hold_valid_d = 1'b0;
            end else begin
                tx_shift_d = TX_IDLE;
                tx_udr_d   = 1'b1;
            end
        end else if (shift_edge) begin
            tx_shift_d = {tx_shift_q[SPI_BYTE_BITS-2:0], 1'b0};
        end

        // Write uses the registered ready, so it lands after any same-cycle load
        if (tx_valid && !hold_valid_q) begin
            hold_d       = tx_data;
            hold_valid_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_shift_q   <= '0;
            bit_cnt_q    <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_ovr_q     <= 1'b0;
            tx_shift_q   <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            tx_udr_q     <= 1'b0;
        end else begin
            rx_shift_q   <= rx_shift_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_ovr_q     <= rx_ovr_d;
            tx_shift_q   <= tx_shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            tx_udr_q     <= tx_udr_d;
        end
    end

    assign spi_miso    = active & tx_shift_q[SPI_BYTE_BITS-1];
    assign spi_miso_oe = active;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = rx_ovr_q;
    assign tx_ready    = ~hold_valid_q;
    assign tx_underrun = tx_udr_q;

endmodule

// File: doc/cva6_spi_slave_clkrec.md
Name: cva6_spi_slave_clkrec

Overview:
SPI slave-side clock recovery and byte shifter: the receiving end of the bus driven by our SPI master clock generator. It oversamples an external SCLK/CS_N/MOSI in the system clock domain, derives sample and shift strobes for all four CPOL/CPHA modes, and assembles MOSI into bytes. It also serialises a transmit byte onto MISO. It sits between the SPI pads and a byte-level slave register/FIFO layer.

Parameters:
SYNC_STAGES, 2, synchroniser depth for spi_sclk, spi_cs_n, spi_mosi (>=2)
TX_IDLE, 8'hFF, byte shifted out when no TX byte is available at a load point

Ports:
clk  in  1  system clock; must be >= 4x SCLK frequency
rstn  in  1  asynchronous active-low reset
en  in  1  block enable; low = ignore bus
cpol  in  1  clock polarity (idle level of SCLK)
cpha  in  1  clock phase
spi_sclk  in  1  external SPI clock (asynchronous)
spi_cs_n  in  1  external chip select, active low (asynchronous)
spi_mosi  in  1  external MOSI (asynchronous)
spi_miso  out  1  MISO data
spi_miso_oe  out  1  MISO output enable
rx_data  out  8  received byte
rx_valid  out  1  rx_data valid, held until rx_ready
rx_ready  in  1  consumer accepts rx_data
rx_overrun  out  1  1-cycle pulse: byte completed while rx_valid && !rx_ready
tx_data  in  8  byte to transmit
tx_valid  in  1  tx_data offered
tx_ready  out  1  TX holding register empty
tx_underrun  out  1  1-cycle pulse: load point with empty holding register

Behaviour:
- Reset: all synchroniser flops 1 for cs_n, 0 otherwise; sclk_q initialised to 0; spi_miso=0, spi_miso_oe=0, rx_data=0, rx_valid=0, rx_overrun=0, tx_underrun=0, holding empty (tx_ready=1), bit_cnt=0.
- Sync: each input passes through SYNC_STAGES flops; edge detect compares last stage with one extra flop -> sclk_rise/sclk_fall, cs_fall/cs_rise (1-cycle strobes).
- active = en && synced cs_n==0. SCLK edges are ignored when !active.
- Sample edge = rise if cpol==cpha, else fall. Shift edge = the opposite edge.
- Sample edge: rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt <= bit_cnt+1 (3-bit, wraps 7->0). On sample with bit_cnt==7: if !rx_valid || rx_ready, rx_data <= completed byte and rx_valid=1 next cycle; else old rx_data kept and rx_overrun pulses.
- rx_valid clears on rx_valid && rx_ready unless a new byte completes in the same cycle; the new byte then wins and rx_valid stays 1.
- TX holding register: write when tx_valid && tx_ready. tx_ready = !hold_valid.
- Load point = cs_fall with cpha=0 (while en), or a shift edge with bit_cnt==0.
- At a load point: tx_shift <= holding (consume) or TX_IDLE (tx_underrun pulse). spi_miso = tx_shift[7] immediately after the load.
- A write in the same cycle as a load lands in the now-empty holding register.
- Shift edge with bit_cnt!=0: tx_shift <= {tx_shift[6:0],1'b0}.
- spi_miso_oe = active. spi_miso = tx_shift[7] while active, else 0.
- cs_rise or en low mid-byte: bit_cnt <= 0; partial rx byte discarded (no rx_valid); tx_shift content abandoned. A consumed holding byte is not restored.
- Latency: rx_valid rises SYNC_STAGES+2 clk cycles after the 8th sample edge at the pin.
- MISO changes SYNC_STAGES+2 cycles after the shift edge at the pin.
- cpol/cpha are sampled continuously. Software changes them only while cs_n is high.

Decomposition:
- Package cva6_spi_pkg: spi_mode_e (MODE0..MODE3 from {cpol,cpha}) and the localparam SPI_BYTE_BITS=8.
- Sub-module cva6_spi_sync_edge: N-stage synchroniser plus rise/fall strobe. Instantiated for sclk and cs_n; mosi uses synchroniser only.

Test Plan:
- Mode 0: cs_n low, MOSI 8'hA5 MSB-first at SCLK = clk/8 -> rx_valid with rx_data=8'hA5. With tx 8'h3C preloaded, master captures 8'h3C on MISO.
- Mode 3 then mode 1 and mode 2: same 8'hA5/8'h3C exchange -> identical results. In cpha=1 modes MSB appears only after the first leading edge.
- Back-to-back bytes 8'h01, 8'h02 with rx_ready held 0 -> rx_data=8'h01 retained, rx_overrun pulses once. Then rx_ready=1 -> rx_valid drops.
- No TX byte written before frame -> MISO shifts 8'hFF and tx_underrun pulses at the load point. tx_ready stays 1.
- cs_n raised after 5 SCLK bits -> no rx_valid. The next full frame of 8'h5A is received correctly (bit_cnt restarted).
- rstn asserted mid-byte, then released -> all outputs at reset values. The next frame of 8'hC3 is received correctly.
